// File: rtl/modulo_n_serial_if.sv
// modulo_n_serial_if: word-in / result-out handshake bundle for the serial modulo checker.
interface modulo_n_serial_if #(parameter int WIDTH = 8, parameter int MOD = 3);
  localparam int RW = $clog2(MOD);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic             out;
  logic [RW-1:0]    rem;
  modport master (output in_valid, in, out_ready, input in_ready, out_valid, out, rem);
  modport slave (input in_valid, in, out_ready, output in_ready, out_valid, out, rem);
endinterface

// File: rtl/modulo_n_serial.sv
// modulo_n_serial: bit-serial, MSB-first word mod MOD with valid/ready handshake.
module modulo_n_serial #(
  parameter int WIDTH = 8,
  parameter int MOD = 3
) (
  input logic             clk,
  input logic             rst_n,
  modulo_n_serial_if.slave bus
);
  localparam int RW = $clog2(MOD);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [RW:0] MODV = (RW + 1)'(MOD);
  if (MOD < 2) begin : g_bad_mod
    $error("modulo_n_serial: MOD must be at least 2");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr;
  logic [RW-1:0] acc, acc_n, rem_q;
  logic [CW-1:0] cnt;
  logic [RW:0] t;
  logic out_q;
  // acc < MOD keeps t < 2*MOD, so one conditional subtract reduces it
  assign t = {acc, sr[WIDTH-1]};
  assign acc_n = t >= MODV ? RW'(t - MODV) : RW'(t);
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.rem = rem_q;
  assign bus.out = out_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.in_valid ? BUSY : IDLE;
      BUSY: state_n = cnt == CW'(1) ? DONE : BUSY;
      DONE: state_n = bus.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      rem_q <= '0;
      out_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        sr <= bus.in;
        acc <= '0;
        cnt <= CW'(WIDTH);
      end else if (state == BUSY) begin
        sr <= sr << 1;
        acc <= acc_n;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          rem_q <= acc_n;
          out_q <= acc_n == '0;
        end
      end
    end
  end
endmodule
